// File: rtl/bypass_writeback_3d_pkg.sv
// Shared types and constants for the sliced writeback / bypass producer.
// Optional feature macro: WB_TAG_CONFLICT_DETECT_EN (see bypass_writeback_3d).
`ifndef ISSUE_WIDTH
`define ISSUE_WIDTH 2
`endif
`ifndef SRAM_DATA_WIDTH
`define SRAM_DATA_WIDTH 8
`endif
`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 6
`endif
`ifndef SIZE_DATA
`define SIZE_DATA (4*`SRAM_DATA_WIDTH)
`endif

package bypass_writeback_3d_pkg;
  localparam int SLICE_CNT = 4;
  localparam int SLICE_0   = 0;
  localparam int SLICE_1   = 1;
  localparam int SLICE_2   = 2;
  localparam int SLICE_3   = 3;

  // Per-stage state at the default core widths.
  typedef struct packed {
    logic                                       valid;
    logic [`SIZE_PHYSICAL_LOG-1:0]              tag;
    logic [SLICE_CNT*`SRAM_DATA_WIDTH-1:0]      slices;
  } wb_stage_t;
endpackage

// File: rtl/bypass_writeback_3d_wb_lane_pipe.sv
// Single-lane W0 -> W1 -> W2 writeback pipeline; each stage keeps only the
// slices it still has to write.
module wb_lane_pipe
  import bypass_writeback_3d_pkg::*;
#(
  parameter int SLICE_W = `SRAM_DATA_WIDTH,
  parameter int TAG_W   = `SIZE_PHYSICAL_LOG
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic [SLICE_CNT*SLICE_W-1:0] in_data,
  output logic                         s0_valid,
  output logic [TAG_W-1:0]             s0_tag,
  output logic [SLICE_CNT*SLICE_W-1:0] s0_data,
  output logic                         s1_valid,
  output logic [TAG_W-1:0]             s1_tag,
  output logic [SLICE_W-1:0]           s1_slice1,
  output logic                         s2_valid,
  output logic [TAG_W-1:0]             s2_tag,
  output logic [SLICE_W-1:0]           s2_slice2,
  output logic [SLICE_W-1:0]           s2_slice3
);
  logic                         v0_reg, v1_reg, v2_reg;
  logic [TAG_W-1:0]             tag0_reg, tag1_reg, tag2_reg;
  logic [SLICE_CNT*SLICE_W-1:0] data0_reg;
  logic [3*SLICE_W-1:0]         data1_reg;  // slices 1..3
  logic [2*SLICE_W-1:0]         data2_reg;  // slices 2..3

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_reg    <= 1'b0;
      v1_reg    <= 1'b0;
      v2_reg    <= 1'b0;
      tag0_reg  <= '0;
      tag1_reg  <= '0;
      tag2_reg  <= '0;
      data0_reg <= '0;
      data1_reg <= '0;
      data2_reg <= '0;
    end else begin
      // Flush kills every in-flight stage and drops the input of the same edge.
      v0_reg    <= in_valid & ~flush;
      v1_reg    <= v0_reg & ~flush;
      v2_reg    <= v1_reg & ~flush;
      tag0_reg  <= in_tag;
      tag1_reg  <= tag0_reg;
      tag2_reg  <= tag1_reg;
      data0_reg <= in_data;
      data1_reg <= data0_reg[SLICE_CNT*SLICE_W-1:SLICE_1*SLICE_W];
      data2_reg <= data1_reg[3*SLICE_W-1:SLICE_W];
    end
  end

  assign s0_valid  = v0_reg;
  assign s0_tag    = tag0_reg;
  assign s0_data   = data0_reg;
  assign s1_valid  = v1_reg;
  assign s1_tag    = tag1_reg;
  assign s1_slice1 = data1_reg[SLICE_W-1:0];
  assign s2_valid  = v2_reg;
  assign s2_tag    = tag2_reg;
  assign s2_slice2 = data2_reg[(SLICE_2-SLICE_2+1)*SLICE_W-1:0];
  assign s2_slice3 = data2_reg[(SLICE_3-SLICE_2+1)*SLICE_W-1:SLICE_W];
endmodule

// File: rtl/bypass_writeback_3d.sv
// Writeback producer: one-cycle bypass broadcast plus staggered slice writes.
// Optional WB_TAG_CONFLICT_DETECT_EN adds a same-tag multi-lane conflict detector.
module bypass_writeback_3d
  import bypass_writeback_3d_pkg::*;
#(
  parameter int LANES   = `ISSUE_WIDTH,
  parameter int SLICE_W = `SRAM_DATA_WIDTH,
  parameter int TAG_W   = `SIZE_PHYSICAL_LOG
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic [LANES-1:0]                             wbValid_i,
  input  logic [LANES-1:0][TAG_W-1:0]                  wbTag_i,
  input  logic [LANES-1:0][SLICE_CNT*SLICE_W-1:0]      wbData_i,
  input  logic                                         flush_i,
  // Per lane: {tag, data, valid}, valid in bit 0.
  output logic [LANES-1:0][TAG_W+SLICE_CNT*SLICE_W:0]  bypassPacket_o,
  output logic [LANES-1:0]                             we0_o,
  output logic [LANES-1:0]                             we1_o,
  output logic [LANES-1:0]                             we23_o,
  output logic [LANES-1:0][TAG_W-1:0]                  waddr0_o,
  output logic [LANES-1:0][TAG_W-1:0]                  waddr1_o,
  output logic [LANES-1:0][TAG_W-1:0]                  waddr23_o,
  output logic [LANES-1:0][SLICE_W-1:0]                wdata0_o,
  output logic [LANES-1:0][SLICE_W-1:0]                wdata1_o,
  output logic [LANES-1:0][SLICE_W-1:0]                wdata2_o,
  output logic [LANES-1:0][SLICE_W-1:0]                wdata3_o,
  output logic                                         conflict_o,
  output logic [7:0]                                   conflictCnt_o
);
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic                         s0_valid;
      logic [TAG_W-1:0]             s0_tag;
      logic [SLICE_CNT*SLICE_W-1:0] s0_data;

      wb_lane_pipe #(.SLICE_W(SLICE_W), .TAG_W(TAG_W)) u_pipe (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_i),
        .in_valid  (wbValid_i[gi]),
        .in_tag    (wbTag_i[gi]),
        .in_data   (wbData_i[gi]),
        .s0_valid  (s0_valid),
        .s0_tag    (s0_tag),
        .s0_data   (s0_data),
        .s1_valid  (we1_o[gi]),
        .s1_tag    (waddr1_o[gi]),
        .s1_slice1 (wdata1_o[gi]),
        .s2_valid  (we23_o[gi]),
        .s2_tag    (waddr23_o[gi]),
        .s2_slice2 (wdata2_o[gi]),
        .s2_slice3 (wdata3_o[gi])
      );

      assign bypassPacket_o[gi] = {s0_tag, s0_data, s0_valid};
      assign we0_o[gi]          = s0_valid;
      assign waddr0_o[gi]       = s0_tag;
      assign wdata0_o[gi]       = s0_data[SLICE_0*SLICE_W +: SLICE_W];
    end
  endgenerate

`ifdef WB_TAG_CONFLICT_DETECT_EN
  logic       conflict_hit;
  logic       conflict_reg;
  logic [7:0] conflict_cnt_reg;

  always_comb begin
    conflict_hit = 1'b0;
    for (int a = 0; a < LANES; a++) begin
      for (int b = a + 1; b < LANES; b++) begin
        if (wbValid_i[a] && wbValid_i[b] && (wbTag_i[a] == wbTag_i[b]))
          conflict_hit = 1'b1;
      end
    end
  end

  // Detection ignores flush: a conflicting edge is counted even when dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_reg     <= 1'b0;
      conflict_cnt_reg <= 8'd0;
    end else if (conflict_hit) begin
      conflict_reg <= 1'b1;
      if (conflict_cnt_reg != 8'hFF)
        conflict_cnt_reg <= conflict_cnt_reg + 8'd1;
    end
  end

  assign conflict_o    = conflict_reg;
  assign conflictCnt_o = conflict_cnt_reg;
`else
  assign conflict_o    = 1'b0;
  assign conflictCnt_o = 8'd0;
`endif
endmodule

// File: tb/tb_bypass_writeback_3d.sv
// Directed self-checking bench for bypass_writeback_3d (LANES=2, SLICE_W=8, TAG_W=4).
module tb_bypass_writeback_3d;
  localparam int LANES   = 2;
  localparam int SLICE_W = 8;
  localparam int TAG_W   = 4;
  localparam int DW      = 4 * SLICE_W;
  localparam int PW      = TAG_W + DW + 1;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [LANES-1:0]                 wbValid_i;
  logic [LANES-1:0][TAG_W-1:0]      wbTag_i;
  logic [LANES-1:0][DW-1:0]         wbData_i;
  logic                             flush_i;
  logic [LANES-1:0][PW-1:0]         bypassPacket_o;
  logic [LANES-1:0]                 we0_o, we1_o, we23_o;
  logic [LANES-1:0][TAG_W-1:0]      waddr0_o, waddr1_o, waddr23_o;
  logic [LANES-1:0][SLICE_W-1:0]    wdata0_o, wdata1_o, wdata2_o, wdata3_o;
  logic                             conflict_o;
  logic [7:0]                       conflictCnt_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bypass_writeback_3d #(.LANES(LANES), .SLICE_W(SLICE_W), .TAG_W(TAG_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .wbValid_i      (wbValid_i),
    .wbTag_i        (wbTag_i),
    .wbData_i       (wbData_i),
    .flush_i        (flush_i),
    .bypassPacket_o (bypassPacket_o),
    .we0_o          (we0_o),
    .we1_o          (we1_o),
    .we23_o         (we23_o),
    .waddr0_o       (waddr0_o),
    .waddr1_o       (waddr1_o),
    .waddr23_o      (waddr23_o),
    .wdata0_o       (wdata0_o),
    .wdata1_o       (wdata1_o),
    .wdata2_o       (wdata2_o),
    .wdata3_o       (wdata3_o),
    .conflict_o     (conflict_o),
    .conflictCnt_o  (conflictCnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [LANES-1:0] byp_valid();
    logic [LANES-1:0] v;
    for (int l = 0; l < LANES; l++) v[l] = bypassPacket_o[l][0];
    return v;
  endfunction

  // Byte k of the back-to-back stimulus for cycle c, lane l.
  function automatic logic [7:0] b2b_byte(int c, int l, int k);
    return 8'(c * 16 + l * 4 + k);
  endfunction

  function automatic logic [DW-1:0] b2b_data(int c, int l);
    return {b2b_byte(c, l, 3), b2b_byte(c, l, 2), b2b_byte(c, l, 1), b2b_byte(c, l, 0)};
  endfunction

  task automatic idle_inputs();
    wbValid_i = '0;
    wbTag_i   = '0;
    wbData_i  = '0;
    flush_i   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    #1;
    total_cnt++;
    if ({we0_o, we1_o, we23_o, byp_valid()} !== '0)
      $display("FAIL reset_enables: got we0=%b we1=%b we23=%b byp=%b, want all 0",
               we0_o, we1_o, we23_o, byp_valid());
    else pass_cnt++;
    total_cnt++;
    if (conflict_o !== 1'b0 || conflictCnt_o !== 8'd0)
      $display("FAIL reset_conflict: got %b/%0d, want 0/0", conflict_o, conflictCnt_o);
    else pass_cnt++;
    total_cnt++;
    if (waddr0_o !== '0 || wdata3_o !== '0)
      $display("FAIL reset_regs: got addr0=%h data3=%h, want 0", waddr0_o, wdata3_o);
    else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single();
    // Inputs set at a negedge, captured at the following posedge.
    wbValid_i   = 2'b01;
    wbTag_i[0]  = 4'd5;
    wbData_i[0] = 32'hDDCCBBAA;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (byp_valid() !== 2'b01 || bypassPacket_o[0] !== {4'd5, 32'hDDCCBBAA, 1'b1})
      $display("FAIL single_bypass: got %h, want %h", bypassPacket_o[0], {4'd5, 32'hDDCCBBAA, 1'b1});
    else pass_cnt++;
    total_cnt++;
    if (we0_o !== 2'b01 || waddr0_o[0] !== 4'd5 || wdata0_o[0] !== 8'hAA || we1_o !== 2'b00)
      $display("FAIL single_w0: got we0=%b a=%0d d=%h we1=%b, want 01/5/aa/00",
               we0_o, waddr0_o[0], wdata0_o[0], we1_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (byp_valid() !== 2'b00 || we0_o !== 2'b00 || we1_o !== 2'b01 ||
        waddr1_o[0] !== 4'd5 || wdata1_o[0] !== 8'hBB || we23_o !== 2'b00)
      $display("FAIL single_w1: got byp=%b we0=%b we1=%b a=%0d d=%h we23=%b, want 00/00/01/5/bb/00",
               byp_valid(), we0_o, we1_o, waddr1_o[0], wdata1_o[0], we23_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (we1_o !== 2'b00 || we23_o !== 2'b01 || waddr23_o[0] !== 4'd5 ||
        wdata2_o[0] !== 8'hCC || wdata3_o[0] !== 8'hDD)
      $display("FAIL single_w2: got we1=%b we23=%b a=%0d d2=%h d3=%h, want 00/01/5/cc/dd",
               we1_o, we23_o, waddr23_o[0], wdata2_o[0], wdata3_o[0]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({we0_o, we1_o, we23_o} !== '0)
      $display("FAIL single_done: got we0=%b we1=%b we23=%b, want 0", we0_o, we1_o, we23_o);
    else pass_cnt++;
    $display("test_single done");
  endtask

  task automatic test_back_to_back();
    int errs;
    for (int i = 0; i < 11; i++) begin
      if (i < 8) begin
        wbValid_i = '1;
        for (int l = 0; l < LANES; l++) begin
          wbTag_i[l]  = 4'(2 * i + l);
          wbData_i[l] = b2b_data(i, l);
        end
      end else idle_inputs();
      @(posedge clk); #1;
      @(negedge clk);
      // After edge i: W0 holds item i, W1 item i-1, W2 item i-2.
      errs = 0;
      for (int l = 0; l < LANES; l++) begin
        if (we0_o[l] !== (i < 8)) errs++;
        else if (i < 8 && (waddr0_o[l] !== 4'(2 * i + l) || wdata0_o[l] !== b2b_byte(i, l, 0) ||
                           bypassPacket_o[l] !== {4'(2 * i + l), b2b_data(i, l), 1'b1})) errs++;
        if (we1_o[l] !== (i >= 1 && i <= 8)) errs++;
        else if (i >= 1 && i <= 8 && (waddr1_o[l] !== 4'(2 * (i - 1) + l) ||
                                      wdata1_o[l] !== b2b_byte(i - 1, l, 1))) errs++;
        if (we23_o[l] !== (i >= 2 && i <= 9)) errs++;
        else if (i >= 2 && i <= 9 && (waddr23_o[l] !== 4'(2 * (i - 2) + l) ||
                                      wdata2_o[l] !== b2b_byte(i - 2, l, 2) ||
                                      wdata3_o[l] !== b2b_byte(i - 2, l, 3))) errs++;
      end
      total_cnt++;
      if (errs != 0)
        $display("FAIL b2b_cycle%0d: got we0=%b we1=%b we23=%b a0=%h a1=%h a23=%h, %0d field errors want 0",
                 i, we0_o, we1_o, we23_o, waddr0_o, waddr1_o, waddr23_o, errs);
      else pass_cnt++;
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    wbValid_i   = 2'b01;
    wbTag_i[0]  = 4'd7;
    wbData_i[0] = 32'h44332211;
    @(posedge clk); #1;
    wbTag_i[0]  = 4'd3;
    wbData_i[0] = 32'h88776655;
    flush_i     = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (we0_o !== 2'b01 || waddr0_o[0] !== 4'd7 || wdata0_o[0] !== 8'h11)
      $display("FAIL flush_slice0: got we0=%b a=%0d d=%h, want 01/7/11", we0_o, waddr0_o[0], wdata0_o[0]);
    else pass_cnt++;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (we0_o !== 2'b00 || byp_valid() !== 2'b00 || we1_o !== 2'b00)
      $display("FAIL flush_kill1: got we0=%b byp=%b we1=%b, want 00/00/00", we0_o, byp_valid(), we1_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (we1_o !== 2'b00 || we23_o !== 2'b00)
      $display("FAIL flush_kill2: got we1=%b we23=%b, want 00/00", we1_o, we23_o);
    else pass_cnt++;
    $display("test_flush done");
  endtask

  task automatic test_async_reset();
    wbValid_i   = 2'b11;
    wbTag_i[0]  = 4'd1;
    wbTag_i[1]  = 4'd2;
    wbData_i[0] = 32'h01020304;
    wbData_i[1] = 32'h05060708;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (we0_o !== 2'b11 || we1_o !== 2'b11 || we23_o !== 2'b11)
      $display("FAIL areset_full: got we0=%b we1=%b we23=%b, want 11/11/11", we0_o, we1_o, we23_o);
    else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++;
    if ({we0_o, we1_o, we23_o, byp_valid()} !== '0)
      $display("FAIL areset_immediate: got we0=%b we1=%b we23=%b byp=%b, want 0",
               we0_o, we1_o, we23_o, byp_valid());
    else pass_cnt++;
    @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if ({we0_o, we1_o, we23_o, byp_valid()} !== '0)
      $display("FAIL areset_hold: got we0=%b we1=%b we23=%b byp=%b, want 0",
               we0_o, we1_o, we23_o, byp_valid());
    else pass_cnt++;
    reset      = 1'b1;
    wbValid_i  = 2'b10;
    wbTag_i[1] = 4'd2;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (we0_o !== 2'b10 || waddr0_o[1] !== 4'd2 || we1_o !== 2'b00 || we23_o !== 2'b00)
      $display("FAIL areset_first_capture: got we0=%b a=%0d we1=%b we23=%b, want 10/2/00/00",
               we0_o, waddr0_o[1], we1_o, we23_o);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    $display("test_async_reset done");
  endtask

  task automatic test_conflict();
    logic       exp_flag;
    logic [7:0] exp_one, exp_sat;
`ifdef WB_TAG_CONFLICT_DETECT_EN
    exp_flag = 1'b1;
    exp_one  = 8'd1;
    exp_sat  = 8'd255;
`else
    exp_flag = 1'b0;
    exp_one  = 8'd0;
    exp_sat  = 8'd0;
`endif
    total_cnt++;
    if (conflict_o !== 1'b0 || conflictCnt_o !== 8'd0)
      $display("FAIL conflict_idle: got %b/%0d, want 0/0", conflict_o, conflictCnt_o);
    else pass_cnt++;
    wbValid_i  = 2'b11;
    wbTag_i[0] = 4'd9;
    wbTag_i[1] = 4'd9;
    @(posedge clk); #1;
    @(negedge clk);
    total_cnt++;
    if (conflict_o !== exp_flag || conflictCnt_o !== exp_one)
      $display("FAIL conflict_first: got %b/%0d, want %b/%0d", conflict_o, conflictCnt_o, exp_flag, exp_one);
    else pass_cnt++;
    repeat (299) @(posedge clk);
    #1;
    idle_inputs();
    @(negedge clk);
    total_cnt++;
    if (conflict_o !== exp_flag || conflictCnt_o !== exp_sat)
      $display("FAIL conflict_saturate: got %b/%0d, want %b/%0d", conflict_o, conflictCnt_o, exp_flag, exp_sat);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (conflict_o !== exp_flag)
      $display("FAIL conflict_sticky: got %b, want %b", conflict_o, exp_flag);
    else pass_cnt++;
    $display("test_conflict done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_conflict();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/bypass_writeback_3d.md
# bypass_writeback_3d

Producer side of the sliced register-read bypass network. Accepts per-lane execution results, broadcasts them on the bypass bus for one cycle, and writes them into the four SRAM_DATA_WIDTH-wide physical register file slices in the same staggered order the read side fetches them: slice 0, then slice 1, then slices 2 and 3. Sits between the functional-unit result latches and the sliced PRF / bypass consumers in RegRead.

## Interface
- LANES, default `ISSUE_WIDTH: number of writeback lanes; one bypass packet per lane.
- SLICE_W, default `SRAM_DATA_WIDTH: width of one PRF slice; `SIZE_DATA = 4*SLICE_W.
- TAG_W, default `SIZE_PHYSICAL_LOG: physical register tag width.
- clk  in  1  core clock; all state on posedge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- wbValid_i  in  LANES  lane result valid this cycle.
- wbTag_i  in  LANES x TAG_W  destination physical register per lane.
- wbData_i  in  LANES x `SIZE_DATA  result data per lane.
- flush_i  in  1  kill all in-flight slice writes and bypass broadcasts.
- bypassPacket_o  out  LANES x bypassPkt  {tag, data, valid} broadcast, registered.
- we0_o, we1_o, we23_o  out  LANES each  write enables for slice 0, slice 1, slices 2+3.
- waddr0_o, waddr1_o, waddr23_o  out  LANES x TAG_W  write addresses per slice group.
- wdata0_o, wdata1_o  out  LANES x SLICE_W  slice 0 and slice 1 data.
- wdata2_o, wdata3_o  out  LANES x SLICE_W  slice 2 and slice 3 data.
- conflict_o  out  1  sticky same-tag conflict flag (only with macro).
- conflictCnt_o  out  8  saturating conflict count (only with macro).

## Operation
- Three-stage per-lane pipeline W0, W1, W2; each stage holds valid, tag, and the slices still to be written.
- W0 captures {wbValid_i, wbTag_i, wbData_i}; drives bypassPacket_o[l] = {tag, full data, valid} and the slice 0 write.
- W1 holds tag and slices 1..3 only; drives the slice 1 write.
- W2 holds tag and slices 2..3 only; drives the slice 2 and slice 3 writes, sharing one enable and address.
- Slice 0 of wbData_i is bits [SLICE_W-1:0]; slice k is bits [(k+1)*SLICE_W-1 : k*SLICE_W].
- Enable of each write port equals the valid bit of its stage. Address equals the stage tag. Data and address are don't-care when the enable is 0, but are driven from registers with no combinational path from inputs.
- flush_i=1 at a posedge clears the W0, W1 and W2 valid bits. An input presented in the same cycle as flush_i is dropped. Partial slice writes already performed stay in the PRF.
- Lanes are independent. No arbitration. Two lanes with the same tag in one cycle both write, and the result is undefined; the optional detector flags this.

## Timing
- Result presented with wbValid_i=1 before edge N:
  - bypassPacket_o valid and we0_o high during cycle N→N+1.
  - we1_o high during N+1→N+2.
  - we23_o high during N+2→N+3.
- Exactly one cycle of bypass valid per result. This matches read-side stage 0/1/2 compares, so a reader sees either the bypass or fully written slices.
- Full throughput: a new result per lane every cycle, with no stalls and no backpressure.
- Reset (async, reset=0): every valid bit, every we*_o, bypassPacket_o.valid, conflict_o and conflictCnt_o go to 0 immediately. Tag and data registers reset to 0.
- Reset deasserted mid-stream: the first capture happens at the first posedge with reset=1. No stale writes from before reset.

## Configuration
- WB_TAG_CONFLICT_DETECT_EN defined:
  - A conflict is any two lanes with wbValid_i=1 and equal wbTag_i at the capture edge.
  - On each conflicting edge, conflict_o sets (sticky until reset) and conflictCnt_o increments, saturating at 255.
  - Detection also runs on an edge where flush_i=1 and counts that conflict.
- WB_TAG_CONFLICT_DETECT_EN undefined: comparators and counter are absent, and conflict_o / conflictCnt_o are tied to 0.

## Structure
- Shared package holds: slice count (4), slice index constants, and the per-stage struct {valid, tag, slices}. bypassPkt stays in the existing shared package.
- One sub-module: wb_lane_pipe, a single-lane W0→W2 pipeline, instantiated LANES times. The conflict detector lives in the top.

## Test plan
- Single result, lane 0, tag 5, data 0xDDCCBBAA (SLICE_W=8) at edge 10 -> bypass valid with tag 5 in cycle 10 only; we0/addr 5/0xAA in cycle 10; we1/0xBB in cycle 11; we23/0xCC,0xDD in cycle 12.
- Back-to-back results on all lanes for 8 cycles with distinct tags -> every slice is written exactly once per tag, in order, with no gaps.
- flush_i=1 one cycle after capturing tag 7 -> slice 0 of tag 7 is written; no we1/we23 for tag 7; the input in the flush cycle is dropped.
- reset=0 asserted asynchronously mid-cycle with all stages valid -> all enables and the bypass valid drop to 0 before the next edge, with no writes after.
- Lanes 0 and 1 both tag 9 on 300 consecutive edges, macro on -> conflict_o=1 and conflictCnt_o saturates at 255. Same stimulus with macro off -> conflict_o=0 and conflictCnt_o=0.
